signed_resize_pipe: RTL and testbench
=====================================

Name: signed_resize_pipe

Overview:
- Parametrised, pipelined, multi-channel signed sample width converter for the audio datapath.
- Widens or narrows two's-complement samples between effect stages: sign-extend, MSB-align, round or saturate.
- Valid/ready streaming interface; reports clipping events.
- Sits between the ADC/effect chain stages wherever sample widths differ.

Parameters:
- in_width, 12, input sample width per channel (>=2)
- out_width, 16, output sample width per channel (>=2; may be <, =, > in_width)
- channels, 2, parallel channels per beat
- cnt_width, 16, width of the clip-event counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  channels*in_width  channel k at bits [k*in_width +: in_width]
- mode  input  1  0 = value-preserving, 1 = MSB-aligned (full-scale-preserving); sampled with the beat
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  channels*out_width  channel k at bits [k*out_width +: out_width]
- clip_flag  output  channels  sticky per-channel saturation flag
- clip_count  output  cnt_width  number of beats with >=1 clipped channel, saturating
- clear  input  1  synchronous clear of clip_flag and clip_count

Behaviour:
- Reset (rst_n low, async): both stage valids 0; out_valid=0, out_data=0, clip_flag=0, clip_count=0. in_ready=1 once rst_n is high.
- Pipeline: two register stages S1 and S2.
  - S1 holds the sign-extended/rounded intermediate of width max(in_width,out_width)+1 plus mode.
  - S2 holds the saturated result and per-channel clip bits.
- Latency is exactly 2 cycles from accepted beat to out_valid when out_ready stays high. Throughput is 1 beat/cycle.
- Handshake:
  - Transfer happens when valid && ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances (combinational).
  - out_data/out_valid are held stable while out_valid && !out_ready.
  - No beat is dropped or duplicated.
- mode 0 (value-preserving):
  - out_width >= in_width: sign-extend; never clips.
  - out_width < in_width: saturate to [-2^(out_width-1), 2^(out_width-1)-1]; clip when out of range.
- mode 1 (MSB-aligned), with d = |out_width - in_width|:
  - out_width >= in_width: output = input << d; never clips.
  - out_width < in_width: output = (input + 2^(d-1)) >>> d, i.e. round half toward +inf, computed in the widened S1 width so it cannot wrap. Result is then saturated; a saturation caused by the rounding increment counts as a clip.
- out_width == in_width: pass-through in both modes; never clips.
- clip_flag[k] is set when a beat with channel k clipped transfers out of S2 (out_valid && out_ready). It stays set until clear or reset.
- clip_count increments by 1 per transferred beat with any clip bit set. It holds at 2^cnt_width-1.
- clear and a clipping transfer in the same cycle: clear wins for that cycle, and the clipping event is lost.
- Reset mid-stream discards in-flight beats; the pipeline is empty on the first cycle after release.
- mode changes between beats take effect per beat, because mode travels with the data.

Test Plan:
- Default params, mode 0, channels {0xFFF, 0x800} -> out {0xFFFF, 0xF800} after exactly 2 cycles; no clip flags; clip_count=0.
- Default params, mode 1, channels {0x7FF, 0x800} -> out {0x7FF0, 0x8000}; no clips.
- in_width=16, out_width=12, mode 0:
  - 0x7FFF -> 0x7FF, clip_flag[ch]=1.
  - 0x8000 -> 0x800, clip.
  - 0x0005 -> 0x005, no clip.
  - clip_count = number of beats containing a clip.
- in_width=16, out_width=12, mode 1:
  - 0x0018 -> 0x002.
  - 0xFFE8 -> 0xFFF.
  - 0x7FF8 -> 0x7FF with clip (rounding overflow).
  - 0x8000 -> 0x800, no clip.
- Backpressure: random in_valid/out_ready over 1000 beats -> output sequence equals reference model in order; out_data stable while stalled; in_ready falls only when S1 and S2 are full and out_ready=0.
- Counter/clear/reset:
  - cnt_width=2 with 5 clipping beats -> clip_count stops at 3.
  - clear concurrent with a clipping transfer -> flags and count read 0 next cycle.
  - rst_n pulse while beats are in flight -> out_valid=0 immediately and no stale beat emerges.

Source files
------------

// File: rtl/signed_resize_pipe.sv
// Multi-channel two's-complement width converter: sign-extend, MSB-align, round, saturate.
// Latency 2 cycles (S1 align/round, S2 saturate); 1 beat/cycle. Backpressure: stages stall from out_ready back to in_ready.
module signed_resize_pipe #(
    parameter int in_width  = 12,
    parameter int out_width = 16,
    parameter int channels  = 2,
    parameter int cnt_width = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [channels*in_width-1:0]  in_data,
    input  logic                          mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [channels*out_width-1:0] out_data,
    output logic [channels-1:0]           clip_flag,
    output logic [cnt_width-1:0]          clip_count,
    input  logic                          clear
);
    localparam int mw = (in_width > out_width) ? in_width : out_width;
    localparam int iw = mw + 1;
    localparam int d  = (out_width > in_width) ? out_width - in_width : in_width - out_width;

    logic                          s1_valid;
    logic                          s2_valid;
    logic                          s1_adv;
    logic                          s2_adv;
    logic [channels*iw-1:0]        s1_dat;
    logic [channels*iw-1:0]        s1_nxt;
    logic [channels*out_width-1:0] s2_dat;
    logic [channels*out_width-1:0] s2_nxt;
    logic [channels-1:0]           s2_clip;
    logic [channels-1:0]           clip_nxt;
    logic                          clip_hit;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    for (genvar k = 0; k < channels; k++) begin : g_ch
        logic signed [in_width-1:0] x;
        logic signed [iw-1:0]       xe;
        logic signed [iw-1:0]       aligned;
        logic signed [iw-1:0]       v;
        logic                       ovf;

        assign x  = in_data[k*in_width +: in_width];
        assign xe = {{(iw-in_width){x[in_width-1]}}, x};

        if (out_width > in_width) begin : g_up
            assign aligned = xe <<< d;
        end else if (out_width < in_width) begin : g_down
            // One guard bit above in_width keeps the rounding add from wrapping.
            localparam logic signed [iw-1:0] half = iw'(1) <<< (d - 1);
            assign aligned = (xe + half) >>> d;
        end else begin : g_same
            assign aligned = xe;
        end

        assign s1_nxt[k*iw +: iw] = mode ? aligned : xe;

        // Fits in out_width iff every bit from the output MSB upward matches the sign.
        assign v   = s1_dat[k*iw +: iw];
        assign ovf = (v[iw-1:out_width-1] != {(iw-out_width+1){v[iw-1]}});
        assign clip_nxt[k] = ovf;
        assign s2_nxt[k*out_width +: out_width] =
            ovf ? {v[iw-1], {(out_width-1){~v[iw-1]}}} : v[out_width-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dat   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) s1_dat <= s1_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_dat   <= '0;
            s2_clip  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_dat  <= s2_nxt;
                s2_clip <= clip_nxt;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_dat;
    assign clip_hit  = s2_valid && out_ready && (|s2_clip);

    // A clear in the same cycle as a clipping transfer drops that event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_flag  <= '0;
            clip_count <= '0;
        end else if (clear) begin
            clip_flag  <= '0;
            clip_count <= '0;
        end else if (clip_hit) begin
            clip_flag <= clip_flag | s2_clip;
            if (clip_count != {cnt_width{1'b1}}) clip_count <= clip_count + cnt_width'(1);
        end
    end
endmodule

// File: tb/tb_signed_resize_pipe.sv
// Bench for signed_resize_pipe: a 12->16 instance and a 16->12 instance with a 2-bit clip counter.
// Directed vector table plus scoreboard with an integer-arithmetic reference model.
module tb_signed_resize_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        iv0, ir0, md0, ov0, or0, clr0;
    logic [23:0] id0;
    logic [31:0] od0;
    logic [1:0]  cf0;
    logic [15:0] cc0;

    logic        iv1, ir1, md1, ov1, or1, clr1;
    logic [31:0] id1;
    logic [23:0] od1;
    logic [1:0]  cf1;
    logic [1:0]  cc1;

    signed_resize_pipe #(.in_width(12), .out_width(16), .channels(2), .cnt_width(16)) u_up (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .mode(md0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .clip_flag(cf0), .clip_count(cc0),
        .clear(clr0));

    signed_resize_pipe #(.in_width(16), .out_width(12), .channels(2), .cnt_width(2)) u_dn (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .mode(md1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .clip_flag(cf1), .clip_count(cc1),
        .clear(clr1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_up(input logic [23:0] x, input logic m);
        logic [31:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 2; k++) begin
            v = $signed(x[k*12 +: 12]);
            if (m) v = v * 16;
            r[k*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    task automatic model_dn(input logic [31:0] x, input logic m, output logic [23:0] y,
                            output logic [1:0] c);
        int v;
        y = '0;
        c = '0;
        for (int k = 0; k < 2; k++) begin
            v = $signed(x[k*16 +: 16]);
            if (m) v = (v + 8) >>> 4;
            if (v > 2047) begin
                y[k*12 +: 12] = 12'h7FF;
                c[k] = 1'b1;
            end else if (v < -2048) begin
                y[k*12 +: 12] = 12'h800;
                c[k] = 1'b1;
            end else begin
                y[k*12 +: 12] = v[11:0];
            end
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [1:0]  c;
    } sb_t;
    sb_t q0[$];
    sb_t q1[$];

    bit          sb_en = 0;
    bit          acc1 = 0;
    int          n_acc1 = 0;
    logic        stall0, stall1;
    logic [31:0] hd0;
    logic [23:0] hd1;
    logic [1:0]  ef0, ef1;
    int          ec0, ec1;

    task automatic sb_reset();
        q0.delete();
        q1.delete();
        stall0 = 0; stall1 = 0;
        ef0 = 0; ef1 = 0;
        ec0 = 0; ec1 = 0;
    endtask

    always @(negedge clk) begin : mon
        sb_t  s;
        logic [23:0] y;
        logic [1:0]  c;
        acc1 = iv1 && ir1;
        if (sb_en) begin
            check("in_ready_up", ir0, !(q0.size() == 2 && !or0));
            if (stall0) begin
                check("hold_valid_up", ov0, 1);
                check("hold_data_up", od0, hd0);
            end
            if (q0.size() == 0) check("empty_valid_up", ov0, 0);
            check("clip_flag_up", cf0, ef0);
            check("clip_count_up", cc0, ec0);
            if (clr0) begin ef0 = 0; ec0 = 0; end
            if (ov0 && or0 && q0.size() != 0) begin
                s = q0.pop_front();
                check("data_up", od0, s.d);
                if (!clr0 && s.c != 0) begin ef0 |= s.c; if (ec0 < 65535) ec0++; end
            end
            stall0 = ov0 && !or0;
            hd0 = od0;
            if (iv0 && ir0) begin
                s.d = model_up(id0, md0);
                s.c = 0;
                q0.push_back(s);
            end

            check("in_ready_dn", ir1, !(q1.size() == 2 && !or1));
            if (stall1) begin
                check("hold_valid_dn", ov1, 1);
                check("hold_data_dn", od1, hd1);
            end
            if (q1.size() == 0) check("empty_valid_dn", ov1, 0);
            check("clip_flag_dn", cf1, ef1);
            check("clip_count_dn", cc1, ec1);
            if (clr1) begin ef1 = 0; ec1 = 0; end
            if (ov1 && or1 && q1.size() != 0) begin
                s = q1.pop_front();
                check("data_dn", od1, s.d);
                if (!clr1 && s.c != 0) begin ef1 |= s.c; if (ec1 < 3) ec1++; end
            end
            stall1 = ov1 && !or1;
            hd1 = od1;
            if (iv1 && ir1) begin
                model_dn(id1, md1, y, c);
                s.d = y;
                s.c = c;
                q1.push_back(s);
                n_acc1++;
            end
        end
    end

    typedef struct {
        bit          which;
        logic        m;
        logic [31:0] din;
        logic [31:0] exp;
        logic [1:0]  clip;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] xf1;
        int         xc1;
        int         n_sent;
        bit         done;

        tbl[0] = '{0, 1'b0, 32'h00800FFF, 32'hF800FFFF, 2'b00};
        tbl[1] = '{0, 1'b1, 32'h008007FF, 32'h80007FF0, 2'b00};
        tbl[2] = '{0, 1'b0, 32'h007FF001, 32'h07FF0001, 2'b00};
        tbl[3] = '{1, 1'b0, 32'h00057FFF, 32'h000057FF, 2'b01};
        tbl[4] = '{1, 1'b0, 32'h80000005, 32'h00800005, 2'b10};
        tbl[5] = '{1, 1'b1, 32'hFFE80018, 32'h00FFF002, 2'b00};
        tbl[6] = '{1, 1'b1, 32'h80007FF8, 32'h008007FF, 2'b01};
        tbl[7] = '{1, 1'b0, 32'hFFFF0000, 32'h00FFF000, 2'b00};

        rst_n = 0; iv0 = 0; iv1 = 0; md0 = 0; md1 = 0; id0 = 0; id1 = 0;
        or0 = 1; or1 = 1; clr0 = 0; clr1 = 0;
        sb_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_up", ov0, 0);
        check("rst_data_up", od0, 0);
        check("rst_flag_up", cf0, 0);
        check("rst_count_up", cc0, 0);
        check("rst_valid_dn", ov1, 0);
        check("rst_data_dn", od1, 0);
        check("rst_flag_dn", cf1, 0);
        check("rst_count_dn", cc1, 0);
        rst_n = 1;
        sb_reset();
        sb_en = 1;
        #1;
        check("rst_ready_up", ir0, 1);
        check("rst_ready_dn", ir1, 1);

        // Directed vectors: exact two-cycle latency, data, flags and count.
        xf1 = 0; xc1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (tbl[i].which) begin iv1 = 1; id1 = tbl[i].din; md1 = tbl[i].m; end
            else begin iv0 = 1; id0 = tbl[i].din[23:0]; md0 = tbl[i].m; end
            @(posedge clk); #1;
            iv0 = 0; iv1 = 0;
            check($sformatf("v%0d_lat1", i), tbl[i].which ? ov1 : ov0, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_lat2", i), tbl[i].which ? ov1 : ov0, 1);
            check($sformatf("v%0d_data", i), tbl[i].which ? {8'h0, od1} : od0, tbl[i].exp);
            if (tbl[i].which) begin
                xf1 |= tbl[i].clip;
                if (tbl[i].clip != 0 && xc1 < 3) xc1++;
            end
            @(posedge clk); #1;
            check($sformatf("v%0d_flags", i), tbl[i].which ? cf1 : cf0, tbl[i].which ? xf1 : 2'b00);
            check($sformatf("v%0d_count", i), tbl[i].which ? {30'h0, cc1} : {16'h0, cc0},
                  tbl[i].which ? xc1 : 0);
        end

        // Counter saturation: five clipping beats into a 2-bit counter.
        clr1 = 1;
        @(posedge clk); #1;
        clr1 = 0;
        check("clear_flags", cf1, 0);
        check("clear_count", cc1, 0);
        iv1 = 1; id1 = 32'h80007FFF; md1 = 0;
        repeat (5) @(posedge clk);
        #1;
        iv1 = 0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_count", cc1, 3);
        check("sat_flags", cf1, 2'b11);

        // Backpressure: both stages fill, in_ready drops, output holds.
        or1 = 0;
        iv1 = 1; id1 = 32'h00010002; md1 = 0;
        @(posedge clk); #1;
        id1 = 32'h00030004;
        check("bp_ready_one", ir1, 1);
        @(posedge clk); #1;
        id1 = 32'h00050006;
        check("bp_ready_full", ir1, 0);
        check("bp_valid_full", ov1, 1);
        @(posedge clk); #1;
        check("bp_ready_stall", ir1, 0);
        check("bp_data_stall", od1, 24'h001002);
        or1 = 1;
        #1;
        check("bp_ready_release", ir1, 1);
        @(posedge clk); #1;
        iv1 = 0;
        repeat (4) @(posedge clk);

        // Clear concurrent with a clipping transfer: clear wins, event lost.
        #1;
        or1 = 0;
        iv1 = 1; id1 = 32'h00007FFF; md1 = 0;
        @(posedge clk); #1;
        iv1 = 0;
        @(posedge clk); #1;
        check("cc_valid", ov1, 1);
        clr1 = 1; or1 = 1;
        @(posedge clk); #1;
        clr1 = 0;
        check("cc_flags", cf1, 0);
        check("cc_count", cc1, 0);
        @(posedge clk); #1;
        check("cc_flags_after", cf1, 0);
        check("cc_count_after", cc1, 0);

        // Random traffic with random backpressure on the narrowing instance.
        n_acc1 = 0; n_sent = 0; done = 0;
        for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
            @(posedge clk); #1;
            or1 = ($urandom_range(0, 3) != 0);
            if (!iv1 || acc1) begin
                if (n_sent < 1000 && $urandom_range(0, 3) != 0) begin
                    id1 = $urandom;
                    md1 = $urandom_range(0, 1);
                    iv1 = 1;
                    n_sent++;
                end else begin
                    iv1 = 0;
                end
            end
            done = (n_acc1 == 1000 && q1.size() == 0 && !iv1);
        end
        iv1 = 0; or1 = 1;
        check("rand_accepted", n_acc1, 1000);
        check("rand_drained", q1.size(), 0);

        // Reset while beats are in flight.
        @(posedge clk); #1;
        iv0 = 1; id0 = 24'h123456; md0 = 1;
        iv1 = 1; id1 = 32'h7FFF7FFF; md1 = 0;
        repeat (2) @(posedge clk);
        #3;
        sb_en = 0;
        rst_n = 0;
        iv0 = 0; iv1 = 0;
        #1;
        check("mid_rst_valid_up", ov0, 0);
        check("mid_rst_valid_dn", ov1, 0);
        check("mid_rst_flags", cf1, 0);
        check("mid_rst_count", cc1, 0);
        @(posedge clk); #1;
        rst_n = 1;
        sb_reset();
        sb_en = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid_up", ov0, 0);
            check("post_rst_valid_dn", ov1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
